// File: rtl/basic_computer_io_pkg.sv
// Shared definitions for the basic computer's I/O section.
//   DEFAULT_DATA_W : default character width (AC[7:0])
//   tx_state_t     : output transmitter state encoding
package basic_computer_io_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESENT      = 2'd1,
    WAIT_RELEASE = 2'd2
  } tx_state_t;

endpackage

// File: rtl/output_fifo.sv
// Synchronous character FIFO between the OUT instruction and the transmitter.
// Ports:
//   clk, reset : clock, synchronous active-high reset (pointers and count)
//   wr_en      : push wr_data; ignored when full
//   wr_data    : character to push
//   rd_en      : pop the head entry; ignored when empty
//   head       : entry at the read pointer
//   count      : occupancy, 0..DEPTH
//   full/empty : occupancy flags decoded from count
module output_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] head,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic              wr_ok;
  logic              rd_ok;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;
  assign head  = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wr_data;
  end

endmodule

// File: rtl/output_register.sv
// Output register of the basic computer: OUT writes AC[7:0] into a small
// buffer, and a transmitter drains it to the display with a four-phase
// valid/ack handshake.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   load_outr    : OUT strobe, writes ac_data into the buffer
//   ac_data      : character from AC[7:0]
//   fgo          : 1 when the buffer can accept a character
//   overflow     : sticky, set by a load into a full buffer
//   output_data  : character presented to the device
//   output_valid : output_data is valid
//   output_ack   : device acknowledge (level, four-phase)
module output_register
  import basic_computer_io_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_outr,
  input  logic [DATA_W-1:0] ac_data,
  output logic              fgo,
  output logic              overflow,
  output logic [DATA_W-1:0] output_data,
  output logic              output_valid,
  input  logic              output_ack
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(FIFO_DEPTH);

  tx_state_t         state;
  logic              pop;
  logic [DATA_W-1:0] head;
  logic [ADDR_W:0]   fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  // The entry stays in the buffer while presented; it leaves only on ack.
  assign pop = (state == PRESENT) && output_ack;
  assign fgo = (fifo_count != FULL_COUNT);

  output_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (load_outr),
    .wr_data (ac_data),
    .rd_en   (pop),
    .head    (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      output_data  <= '0;
      output_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (load_outr && fifo_full) overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            output_data  <= head;
            output_valid <= 1'b1;
            state        <= PRESENT;
          end
        end
        PRESENT: begin
          if (output_ack) begin
            output_valid <= 1'b0;
            state        <= WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          // Ack must be seen low before the next character is offered.
          if (!output_ack) state <= IDLE;
        end
        default: begin
          output_valid <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/output_register.md
Name: output_register

Overview:
- Output-side counterpart of the keyboard input register in the basic computer's I/O section.
- The control unit executes OUT, which writes AC[7:0] into a small character buffer. Buffer state is reported to the control unit through the FGO flag.
- A transmitter state machine drains the buffer towards the display/terminal device using a four-phase valid/ack handshake.

Parameters:
- DATA_W, 8, character width in bits.
- FIFO_DEPTH, 4, buffer entries; must be a power of two, minimum 2.
- ADDR_W, 2, log2(FIFO_DEPTH); pointer width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load_outr  input  1  one-cycle strobe from the control unit (OUT instruction): write ac_data into the buffer.
- ac_data  input  DATA_W  character from AC[7:0].
- fgo  output  1  output flag; 1 = buffer can accept a character. Used by SKO and by the interrupt logic.
- overflow  output  1  sticky; set when load_outr arrives with the buffer full.
- output_data  output  DATA_W  character presented to the display device.
- output_valid  output  1  character on output_data is valid.
- output_ack  input  1  device acknowledge, level-sensitive, four-phase.

Behaviour:
- Reset: state IDLE, read/write pointers 0, count 0, output_data 0, output_valid 0, overflow 0. fgo reads 1 on the cycle after reset.
- Reset mid-handshake: the in-flight character and all buffered characters are discarded, and output_valid is 0 after the reset edge.
- Buffer: synchronous FIFO, count in 0..FIFO_DEPTH.
  - Pointers wrap modulo FIFO_DEPTH.
  - fgo = (count != FIFO_DEPTH), driven combinationally from registered count.
- Write:
  - At an edge with load_outr=1 and count<FIFO_DEPTH: mem[wptr] <= ac_data, wptr++, count++.
  - At an edge with load_outr=1 and count==FIFO_DEPTH: the write is dropped, no pointer or count change, overflow <= 1.
  - overflow clears only on reset.
- Transmitter FSM, three states:
  - IDLE: if count>0 at the edge, then output_data <= mem[rptr], output_valid <= 1, go to PRESENT. Otherwise stay.
  - PRESENT: hold output_data and output_valid. When output_ack=1 at the edge: output_valid <= 0, rptr++, count--, go to WAIT_RELEASE.
  - WAIT_RELEASE: when output_ack=0 at the edge, go to IDLE. Otherwise stay.
  - output_data holds its last value after the pop; no re-zeroing.
- The entry is popped only at ack, not when it is presented. Count therefore includes the character being presented.
- Latency:
  - load_outr at edge k into an empty buffer gives output_valid=1 after edge k+1.
  - Minimum 3 cycles per character with an immediate ack (PRESENT, WAIT_RELEASE, IDLE).
- Simultaneous write and pop at the same edge:
  - count is unchanged and both pointers advance.
  - When count==FIFO_DEPTH, the write is still refused. fgo is from pre-edge count, so no same-cycle bypass.
- output_ack=1 while in IDLE is ignored. No character is presented until ack has been seen low in WAIT_RELEASE.
- No combinational path from output_ack to any output.

Decomposition:
- Shared package basic_computer_io_pkg holds:
  - DATA_W default.
  - Transmitter state encoding: IDLE=2'd0, PRESENT=2'd1, WAIT_RELEASE=2'd2; 2'd3 returns to IDLE.
- One sub-module, output_fifo: the synchronous FIFO with wr_en, rd_en, count, full, empty and head data.
- The FSM and flag logic stay in output_register.

Test Plan:
- Reset, then idle 5 cycles -> fgo=1, output_valid=0, output_data=8'h00, overflow=0.
- One load of 8'h41, device acks 2 cycles after valid and releases 1 cycle later -> valid rises the cycle after load, output_data=8'h41 until ack, valid falls after the ack edge, FSM back in IDLE 1 cycle after ack drops.
- Five back-to-back loads 8'h01..8'h05 with ack held low -> fgo=0 after the 4th, 5th load dropped, overflow=1, device later receives 8'h01..8'h04 in order, fgo=1 after the first pop.
- Buffer full, load_outr coincident with the ack pop edge -> load refused, count goes to 3, overflow=1.
- Ack held high across two characters -> second character not presented until ack goes low, then presented in the next IDLE cycle.
- Reset asserted while in PRESENT with 3 characters buffered -> output_valid=0 after the edge, count=0, fgo=1, no character emitted after reset deasserts.
